// File: rtl/des_pkg.sv
// des_pkg: shared DES datapath constants and helpers
package des_pkg;
  localparam int DES_BLOCK_W = 64;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/des_fifo_ram.sv
// des_fifo_ram: DEPTH x WIDTH storage with sync write and async read, no reset
module des_fifo_ram
  import des_pkg::*;
#(
  parameter int WIDTH = DES_BLOCK_W,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/des_block_fifo.sv
// des_block_fifo: first-word-fall-through ready/valid buffer for DES blocks
module des_block_fifo
  import des_pkg::*;
#(
  parameter int WIDTH    = DES_BLOCK_W,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AW       = ptr_w(DEPTH),
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             almost_full
);
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push, pop;
  assign in_ready    = level != LW'(DEPTH);
  assign out_valid   = level != '0;
  assign almost_full = level >= LW'(AF_LEVEL);
  assign push        = in_valid && in_ready && !flush && !rst;
  assign pop         = out_valid && out_ready && !flush && !rst;
  // Gate storage so stale entries never leak out while empty
  assign out_data    = out_valid ? rdata : '0;
  des_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end
endmodule
